tx_queue_sched: RTL and testbench
=================================

TX_QUEUE_SCHED -- requirements
Module: tx_queue_sched

Interface
REQ-001 SHALL have parameter RETRY_WIDTH, default 4, width of retry limit and retry counter.
REQ-002 SHALL have parameter TIMEOUT_WIDTH, default 16, width of ACK timeout in microseconds.
REQ-003 SHALL have port clk  input  1  single clock for all state.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port tsf_pulse_1M  input  1  one-cycle pulse every 1 us.
REQ-006 SHALL have port queue_req  input  4  bit i high: queue i holds a frame.
REQ-007 SHALL have port slice_en  input  4  bit i high: queue i is inside its time slice.
REQ-008 SHALL have port queue_ack_req  input  4  bit i high: head frame of queue i expects an ACK.
REQ-009 SHALL have port backoff_done  input  1  CSMA/CA backoff complete, channel granted.
REQ-010 SHALL have port max_retry  input  RETRY_WIDTH  retransmissions allowed per frame.
REQ-011 SHALL have port ack_timeout_us  input  TIMEOUT_WIDTH  ACK wait after tx_done, in us.
REQ-012 SHALL have port tx_start_ack  input  1  TX engine accepted start request.
REQ-013 SHALL have port tx_done  input  1  one-cycle pulse, last sample sent.
REQ-014 SHALL have port ack_ok  input  1  one-cycle pulse, valid ACK for us received.
REQ-015 SHALL have port tx_start_req  output  1  request TX engine to send the selected queue.
REQ-016 SHALL have port tx_queue_sel  output  2  index of the locked queue.
REQ-017 SHALL have port retrans_in_progress  output  1  locked frame is a retransmission; drives CSMA/CA.
REQ-018 SHALL have port queue_pop  output  4  one-cycle pulse on bit i: frame of queue i finished OK.
REQ-019 SHALL have port queue_drop  output  4  one-cycle pulse on bit i: frame of queue i dropped after retries.
REQ-020 SHALL have port sched_state  output  3  current FSM state for debug.

Function
REQ-021 SHALL define eligible[i] = queue_req[i] AND slice_en[i].
REQ-022 SHALL implement states IDLE=0, WAIT_BACKOFF=1, START=2, TX=3, WAIT_ACK=4.
REQ-023 IDLE, unlocked: if any eligible bit is set, SHALL lock the first eligible queue in round-robin order last_served+1, +2, +3, +0 (mod 4), write it to tx_queue_sel, and go to WAIT_BACKOFF next cycle.
REQ-024 IDLE, locked (retrans_in_progress=1): SHALL NOT re-arbitrate; go to WAIT_BACKOFF only when eligible[tx_queue_sel]=1.
REQ-025 WAIT_BACKOFF: if eligible[sel]=0, SHALL return to IDLE, keeping lock, retry count and retrans flag; else if backoff_done=1, SHALL go to START.
REQ-026 START: tx_start_req SHALL be 1 and stay 1 until the cycle tx_start_ack=1 is sampled; then go to TX and drive tx_start_req=0 next cycle. Eligibility changes in START SHALL be ignored.
REQ-027 TX: on tx_done, if queue_ack_req[sel]=1, SHALL load ack_timer=ack_timeout_us and go to WAIT_ACK; otherwise SHALL take the success path. tx_done outside TX SHALL be ignored.
REQ-028 WAIT_ACK: ack_timer SHALL decrement on each tsf_pulse_1M and saturate at 0. ack_ok SHALL take the success path. ack_timer==0 without ack_ok SHALL take the failure path. ack_ok and timeout in the same cycle SHALL count as success.
REQ-029 Success path: one-cycle queue_pop[sel]=1, retry_cnt=0, retrans_in_progress=0, last_served=sel, unlock, IDLE.
REQ-030 Failure path, retry_cnt==max_retry: one-cycle queue_drop[sel]=1, retry_cnt=0, retrans_in_progress=0, last_served=sel, unlock, IDLE.
REQ-031 Failure path, retry_cnt<max_retry: retry_cnt+1, retrans_in_progress=1, lock kept, IDLE.
REQ-032 max_retry=0 SHALL drop on the first failure. ack_timeout_us=0 SHALL fail on the first WAIT_ACK cycle unless ack_ok is present in that cycle.
REQ-033 queue_pop and queue_drop SHALL be registered, at most one bit set, and never both set in the same cycle.
REQ-034 ack_ok outside WAIT_ACK SHALL be ignored.

Reset
REQ-035 With rstn=0, SHALL set: state IDLE, tx_start_req=0, tx_queue_sel=0, retrans_in_progress=0, queue_pop=0, queue_drop=0, retry_cnt=0, ack_timer=0, last_served=3, unlocked.
REQ-036 Reset asserted mid-operation (any state) SHALL abort with no pop/drop pulse; the first grant after reset SHALL follow REQ-023 from queue 0.

Verification
REQ-037 queue_req=4'b1111, slice_en=4'b1111, no ACK required, backoff_done=1 -> grants SHALL occur in order 0,1,2,3,0, with one queue_pop pulse each.
REQ-038 queue_req=4'b0101, slice_en=4'b0100 -> only queue 2 is locked; then slice_en[2] falls in WAIT_BACKOFF -> state returns to IDLE and tx_start_req never rises.
REQ-039 ack required, ack_timeout_us=5, no ack_ok, max_retry=2 -> three transmissions occur, retrans_in_progress=1 during the 2nd and 3rd, then one queue_drop[sel] pulse and retrans_in_progress=0.
REQ-040 ack_ok on the same cycle ack_timer reaches 0 -> queue_pop pulse, no retry.
REQ-041 tx_start_ack held low 10 cycles -> tx_start_req stays 1 for those 10 cycles; tx_done pulses during START are ignored.
REQ-042 rstn pulsed low in WAIT_ACK after one failure -> all outputs return to reset values, and the next grant goes to queue 0.

Source files
------------

// File: rtl/tx_queue_sched.sv
// TX queue scheduler: round-robin arbitration over four queues, CSMA/CA handshake,
// ACK timeout supervision and bounded retransmission with pop/drop reporting.
module tx_queue_sched #(
  parameter int RETRY_WIDTH   = 4,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     tsf_pulse_1M,
  input  logic [3:0]               queue_req,
  input  logic [3:0]               slice_en,
  input  logic [3:0]               queue_ack_req,
  input  logic                     backoff_done,
  input  logic [RETRY_WIDTH-1:0]   max_retry,
  input  logic [TIMEOUT_WIDTH-1:0] ack_timeout_us,
  input  logic                     tx_start_ack,
  input  logic                     tx_done,
  input  logic                     ack_ok,
  output logic                     tx_start_req,
  output logic [1:0]               tx_queue_sel,
  output logic                     retrans_in_progress,
  output logic [3:0]               queue_pop,
  output logic [3:0]               queue_drop,
  output logic [2:0]               sched_state
);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    WAIT_BACKOFF = 3'd1,
    START        = 3'd2,
    TX           = 3'd3,
    WAIT_ACK     = 3'd4
  } state_t;

  state_t                   state;
  logic [RETRY_WIDTH-1:0]   retry_cnt;
  logic [TIMEOUT_WIDTH-1:0] ack_timer;
  logic [1:0]               last_served;
  logic                     locked;

  logic [3:0] eligible;
  logic       grant_found;
  logic [1:0] grant_idx;
  logic [1:0] cand;
  logic [3:0] sel_onehot;
  logic       frame_ok;
  logic       frame_fail;
  logic       give_up;

  // Round-robin search starts just after the last served queue; k=4 wraps onto it.
  always_comb begin
    eligible    = queue_req & slice_en;
    grant_found = 1'b0;
    grant_idx   = last_served;
    cand        = '0;
    for (int unsigned k = 1; k <= 4; k++) begin
      cand = last_served + 2'(k);
      if (!grant_found && eligible[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    sel_onehot = 4'b0001 << tx_queue_sel;
    frame_ok   = (state == TX && tx_done && !queue_ack_req[tx_queue_sel]) ||
                 (state == WAIT_ACK && ack_ok);
    frame_fail = (state == WAIT_ACK) && !ack_ok && (ack_timer == '0);
    give_up    = (retry_cnt >= max_retry);
  end

  assign sched_state = state;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state               <= IDLE;
      tx_start_req        <= 1'b0;
      tx_queue_sel        <= '0;
      retrans_in_progress <= 1'b0;
      queue_pop           <= '0;
      queue_drop          <= '0;
      retry_cnt           <= '0;
      ack_timer           <= '0;
      last_served         <= 2'd3;
      locked              <= 1'b0;
    end else begin
      queue_pop  <= '0;
      queue_drop <= '0;
      case (state)
        IDLE: begin
          if (!locked) begin
            if (grant_found) begin
              tx_queue_sel <= grant_idx;
              locked       <= 1'b1;
              state        <= WAIT_BACKOFF;
            end
          end else if (eligible[tx_queue_sel]) begin
            state <= WAIT_BACKOFF;
          end
        end
        WAIT_BACKOFF: begin
          if (!eligible[tx_queue_sel]) begin
            state <= IDLE;
          end else if (backoff_done) begin
            state        <= START;
            tx_start_req <= 1'b1;
          end
        end
        START: begin
          if (tx_start_ack) begin
            state        <= TX;
            tx_start_req <= 1'b0;
          end
        end
        TX: begin
          if (tx_done && queue_ack_req[tx_queue_sel]) begin
            ack_timer <= ack_timeout_us;
            state     <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (tsf_pulse_1M && ack_timer != '0)
            ack_timer <= ack_timer - TIMEOUT_WIDTH'(1);
        end
        default: state <= IDLE;
      endcase

      // Frame completion overrides the per-state updates above (last assignment wins).
      if (frame_ok || (frame_fail && give_up)) begin
        if (frame_ok) queue_pop  <= sel_onehot;
        else          queue_drop <= sel_onehot;
        retry_cnt           <= '0;
        retrans_in_progress <= 1'b0;
        last_served         <= tx_queue_sel;
        locked              <= 1'b0;
        state               <= IDLE;
      end else if (frame_fail) begin
        retry_cnt           <= retry_cnt + RETRY_WIDTH'(1);
        retrans_in_progress <= 1'b1;
        state               <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_tx_queue_sched.sv
// Bench for tx_queue_sched: table of frames with a pop/drop scoreboard, plus
// hand-written sequences for backoff abort, start handshake stall and mid-ACK reset.
module tb_tx_queue_sched;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        tsf_pulse_1M = 1'b0;
  logic [3:0]  queue_req = '0;
  logic [3:0]  slice_en = '0;
  logic [3:0]  queue_ack_req = '0;
  logic        backoff_done = 1'b1;
  logic [3:0]  max_retry = '0;
  logic [15:0] ack_timeout_us = '0;
  logic        tx_start_ack = 1'b0;
  logic        tx_done = 1'b0;
  logic        ack_ok = 1'b0;
  logic        tx_start_req;
  logic [1:0]  tx_queue_sel;
  logic        retrans_in_progress;
  logic [3:0]  queue_pop;
  logic [3:0]  queue_drop;
  logic [2:0]  sched_state;

  int tests = 0;
  int fails = 0;

  // Expected completions: {drop bits, pop bits}.
  logic [7:0] sb[$];

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  slice;
    logic [3:0]  ackreq;
    logic [3:0]  mretry;
    logic [15:0] tmo;
    int          nfail;
    logic [1:0]  sel;
  } vec_t;

  vec_t vecs[13];

  tx_queue_sched #(.RETRY_WIDTH(4), .TIMEOUT_WIDTH(16)) dut (
    .clk                 (clk),
    .rstn                (rstn),
    .tsf_pulse_1M        (tsf_pulse_1M),
    .queue_req           (queue_req),
    .slice_en            (slice_en),
    .queue_ack_req       (queue_ack_req),
    .backoff_done        (backoff_done),
    .max_retry           (max_retry),
    .ack_timeout_us      (ack_timeout_us),
    .tx_start_ack        (tx_start_ack),
    .tx_done             (tx_done),
    .ack_ok              (ack_ok),
    .tx_start_req        (tx_start_req),
    .tx_queue_sel        (tx_queue_sel),
    .retrans_in_progress (retrans_in_progress),
    .queue_pop           (queue_pop),
    .queue_drop          (queue_drop),
    .sched_state         (sched_state)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (3) @(posedge clk);
      #1 tsf_pulse_1M = 1'b1;
      @(posedge clk);
      #1 tsf_pulse_1M = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [7:0] e;
    if ((queue_pop | queue_drop) != 4'b0000) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", 32'({queue_drop, queue_pop}), 32'h0);
      end else begin
        e = sb.pop_front();
        check("pop_drop_pulse", 32'({queue_drop, queue_pop}), 32'(e));
      end
    end
  end

  task automatic wait_start();
    int i;
    for (i = 0; i < 50; i++) begin
      if (tx_start_req) break;
      tick();
    end
    if (i == 50) check("start_timeout", 32'(tx_start_req), 32'h1);
  endtask

  task automatic wait_leave_ack();
    int i;
    for (i = 0; i < 500; i++) begin
      if (sched_state != 3'd4) break;
      tick();
    end
    if (i == 500) check("ack_wait_timeout", 32'(sched_state), 32'h0);
  endtask

  // Entered with the DUT in START; leaves it just after the tx_done edge.
  task automatic serve(input int hold, input bit done_glitch, input bit ack_in_tx);
    for (int i = 0; i < hold; i++) begin
      tx_done = (done_glitch && i == 3);
      tick();
      tx_done = 1'b0;
      check("start_hold_req", 32'(tx_start_req), 32'h1);
      check("start_hold_state", 32'(sched_state), 32'h2);
    end
    tx_start_ack = 1'b1;
    tick();
    tx_start_ack = 1'b0;
    check("tx_req_low", 32'(tx_start_req), 32'h0);
    check("tx_state", 32'(sched_state), 32'h3);
    if (ack_in_tx) begin
      ack_ok = 1'b1;
      tick();
      ack_ok = 1'b0;
      check("ack_in_tx_ignored", 32'(sched_state), 32'h3);
    end
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    bit need_ack, drop;
    int attempts;
    queue_req      = v.req;
    slice_en       = v.slice;
    queue_ack_req  = v.ackreq;
    max_retry      = v.mretry;
    ack_timeout_us = v.tmo;
    need_ack = v.ackreq[v.sel];
    drop     = need_ack && (v.nfail > int'(v.mretry));
    attempts = !need_ack ? 1 : (drop ? int'(v.mretry) + 1 : v.nfail + 1);
    sb.push_back(drop ? {4'b0001 << v.sel, 4'b0000} : {4'b0000, 4'b0001 << v.sel});
    for (int a = 0; a < attempts; a++) begin
      wait_start();
      check("grant_sel", 32'(tx_queue_sel), 32'(v.sel));
      check("retrans_flag", 32'(retrans_in_progress), 32'(a > 0));
      serve(0, 1'b0, 1'b0);
      if (!need_ack) begin
        check("noack_idle", 32'(sched_state), 32'h0);
        check("noack_retrans", 32'(retrans_in_progress), 32'h0);
      end else begin
        check("wait_ack_state", 32'(sched_state), 32'h4);
        if (a < v.nfail) begin
          wait_leave_ack();
          check("fail_idle", 32'(sched_state), 32'h0);
          check("fail_retrans", 32'(retrans_in_progress), 32'(a + 1 < attempts));
        end else begin
          ack_ok = 1'b1;
          tick();
          ack_ok = 1'b0;
          check("ack_idle", 32'(sched_state), 32'h0);
          check("ack_retrans", 32'(retrans_in_progress), 32'h0);
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    //            req      slice    ackreq   mretry tmo     nfail sel
    vecs[0]  = '{4'b1111, 4'b1111, 4'b0000, 4'd0, 16'd0, 0, 2'd0};
    vecs[1]  = '{4'b1111, 4'b1111, 4'b0000, 4'd0, 16'd0, 0, 2'd1};
    vecs[2]  = '{4'b1111, 4'b1111, 4'b0000, 4'd0, 16'd0, 0, 2'd2};
    vecs[3]  = '{4'b1111, 4'b1111, 4'b0000, 4'd0, 16'd0, 0, 2'd3};
    vecs[4]  = '{4'b1111, 4'b1111, 4'b0000, 4'd0, 16'd0, 0, 2'd0};
    vecs[5]  = '{4'b0101, 4'b0100, 4'b0000, 4'd0, 16'd0, 0, 2'd2};
    vecs[6]  = '{4'b1010, 4'b1111, 4'b0000, 4'd0, 16'd0, 0, 2'd3};
    vecs[7]  = '{4'b1010, 4'b1010, 4'b0000, 4'd0, 16'd0, 0, 2'd1};
    vecs[8]  = '{4'b0001, 4'b0001, 4'b0001, 4'd3, 16'd2, 1, 2'd0};
    vecs[9]  = '{4'b1111, 4'b1111, 4'b1111, 4'd0, 16'd0, 1, 2'd1};
    vecs[10] = '{4'b1111, 4'b1111, 4'b0100, 4'd2, 16'd5, 3, 2'd2};
    vecs[11] = '{4'b1001, 4'b1001, 4'b1000, 4'd1, 16'd3, 1, 2'd3};
    vecs[12] = '{4'b1000, 4'b1000, 4'b1000, 4'd1, 16'd0, 0, 2'd3};

    rstn = 1'b0;
    repeat (3) tick();
    check("rst_state", 32'(sched_state), 32'h0);
    check("rst_req", 32'(tx_start_req), 32'h0);
    check("rst_sel", 32'(tx_queue_sel), 32'h0);
    check("rst_retrans", 32'(retrans_in_progress), 32'h0);
    check("rst_pop_drop", 32'({queue_drop, queue_pop}), 32'h0);
    rstn = 1'b1;

    for (int n = 0; n < 13; n++) run_vec(vecs[n]);

    // Eligibility lost while waiting for backoff: back to IDLE, no start request.
    queue_req = 4'b0101; slice_en = 4'b0100; queue_ack_req = '0; backoff_done = 1'b0;
    tick();
    check("bo_state", 32'(sched_state), 32'h1);
    check("bo_sel", 32'(tx_queue_sel), 32'h2);
    slice_en = 4'b0000;
    tick();
    check("bo_abort_idle", 32'(sched_state), 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bo_no_req", 32'({sched_state, tx_start_req}), 32'h0);
    end
    sb.push_back({4'b0000, 4'b0100});
    slice_en = 4'b0100; backoff_done = 1'b1;
    wait_start();
    check("bo_resume_sel", 32'(tx_queue_sel), 32'h2);
    serve(0, 1'b0, 1'b0);

    // Start handshake stalled 10 cycles with a stray tx_done; ack_ok during TX ignored.
    queue_req = 4'b0001; slice_en = 4'b0001; queue_ack_req = 4'b0001; ack_timeout_us = 16'd50;
    sb.push_back({4'b0000, 4'b0001});
    wait_start();
    check("stall_sel", 32'(tx_queue_sel), 32'h0);
    serve(10, 1'b1, 1'b1);
    check("stall_wait_ack", 32'(sched_state), 32'h4);
    ack_ok = 1'b1;
    tick();
    ack_ok = 1'b0;
    check("stall_done_idle", 32'(sched_state), 32'h0);

    // Reset in WAIT_ACK after one failed attempt aborts silently.
    queue_req = 4'b0100; slice_en = 4'b0100; queue_ack_req = 4'b0100;
    max_retry = 4'd2; ack_timeout_us = 16'd0;
    wait_start();
    check("rr_sel", 32'(tx_queue_sel), 32'h2);
    serve(0, 1'b0, 1'b0);
    wait_leave_ack();
    check("rr_retrans", 32'(retrans_in_progress), 32'h1);
    wait_start();
    serve(0, 1'b0, 1'b0);
    check("rr_in_wait_ack", 32'(sched_state), 32'h4);
    rstn = 1'b0;
    #1;
    check("rr_rst_outputs",
          32'({sched_state, tx_start_req, tx_queue_sel, retrans_in_progress, queue_drop, queue_pop}),
          32'h0);
    tick();
    rstn = 1'b1;
    queue_req = 4'b1111; slice_en = 4'b1111; queue_ack_req = '0;
    sb.push_back({4'b0000, 4'b0001});
    wait_start();
    check("rr_first_grant", 32'(tx_queue_sel), 32'h0);
    serve(0, 1'b0, 1'b0);
    queue_req = '0;
    repeat (3) tick();
    check("sb_empty", 32'(sb.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
